// File: rtl/ysyx_22050710_sram_pkg.sv
// Shared definitions for the SRAM-like responder: default widths and the
// packing of a queued request entry {addr, is_wr, wmask, wdata}, LSB first
// from wdata upwards.
package ysyx_22050710_sram_pkg;

    localparam int DEF_ADDR_WD  = 32;
    localparam int DEF_DATA_WD  = 64;
    localparam int DEF_WMASK_WD = DEF_DATA_WD / 8;

    // Number of byte-offset bits inside one data word at the default width.
    localparam int OFF_WD = $clog2(DEF_WMASK_WD);

    // Byte-offset bits for an arbitrary byte-enable width.
    function automatic int offWd(input int wmaskWd);
        return $clog2(wmaskWd);
    endfunction

    // Total width of one queued request entry.
    function automatic int entryWd(input int addrWd, input int dataWd, input int wmaskWd);
        return addrWd + 1 + wmaskWd + dataWd;
    endfunction

    // Lowest bit of the write-mask field (wdata occupies the bottom bits).
    function automatic int wmaskLsb(input int dataWd);
        return dataWd;
    endfunction

    // Position of the is-write flag.
    function automatic int isWrBit(input int dataWd, input int wmaskWd);
        return dataWd + wmaskWd;
    endfunction

    // Lowest bit of the request address field.
    function automatic int addrLsb(input int dataWd, input int wmaskWd);
        return dataWd + wmaskWd + 1;
    endfunction

endpackage

// File: rtl/ysyx_22050710_sync_fifo.sv
// Small in-order request queue with full/empty/count status. Pushes while
// full and pops while empty are ignored; pointers wrap modulo DEPTH, so
// DEPTH need not be a power of two.
module ysyx_22050710_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             pushData_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             headData_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WD = $clog2(DEPTH + 1);
    localparam logic [PTR_WD-1:0] LAST_PTR = PTR_WD'(DEPTH - 1);
    localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DEPTH);

    logic [WIDTH-1:0]  slots_q [DEPTH];
    logic [PTR_WD-1:0] headPtr_q, headPtr_d;
    logic [PTR_WD-1:0] tailPtr_q, tailPtr_d;
    logic [CNT_WD-1:0] count_q, count_d;
    logic              doPush, doPop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign doPush     = push_i & ~full_o;
    assign doPop      = pop_i & ~empty_o;
    assign headData_o = slots_q[headPtr_q];

    // Next pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (doPush) begin
            tailPtr_d = (tailPtr_q == LAST_PTR) ? '0 : tailPtr_q + PTR_WD'(1);
        end
        if (doPop) begin
            headPtr_d = (headPtr_q == LAST_PTR) ? '0 : headPtr_q + PTR_WD'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_WD'(1);
            2'b01:   count_d = count_q - CNT_WD'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset drops every queued entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

    // Entry storage; contents are meaningless once the count says the slot is free.
    always_ff @(posedge clk_i) begin
        if (doPush && !rst_i) begin
            slots_q[tailPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/ysyx_22050710_sram_responder.sv
// Slave side of the core's SRAM-like req/addr_ok/data_ok interface, backed
// by a word array. Requests queue in order; each answers LATENCY cycles
// after reaching the head of the queue. Writes land in memory only when
// they are answered, so a read never sees a write still waiting behind it.
module ysyx_22050710_sram_responder
    import ysyx_22050710_sram_pkg::*;
#(
    parameter int                      SRAM_ADDR_WD  = 32,
    parameter int                      SRAM_DATA_WD  = 64,
    parameter int                      SRAM_WMASK_WD = 8,
    parameter int                      DEPTH         = 2,
    parameter int                      LATENCY       = 1,
    parameter int                      MEM_WORDS     = 256,
    parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR     = 32'h8000_0000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [SRAM_ADDR_WD-1:0]   i_sram_addr,
    input  logic                      i_sram_ren,
    input  logic                      i_sram_wen,
    input  logic [SRAM_WMASK_WD-1:0]  i_sram_wmask,
    input  logic [SRAM_DATA_WD-1:0]   i_sram_wdata,
    output logic                      o_sram_addr_ok,
    output logic                      o_sram_data_ok,
    output logic [SRAM_DATA_WD-1:0]   o_sram_rdata
);

    localparam int BYTE_OFF_WD = offWd(SRAM_WMASK_WD);
    localparam int ENTRY_WD    = entryWd(SRAM_ADDR_WD, SRAM_DATA_WD, SRAM_WMASK_WD);
    localparam int MASK_LSB    = wmaskLsb(SRAM_DATA_WD);
    localparam int ISWR_BIT    = isWrBit(SRAM_DATA_WD, SRAM_WMASK_WD);
    localparam int ADDR_LSB    = addrLsb(SRAM_DATA_WD, SRAM_WMASK_WD);
    localparam int CNT_WD      = $clog2(DEPTH + 1);
    localparam int LAT_WD      = $clog2(LATENCY + 1);
    localparam int IDX_WD      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [LAT_WD-1:0] LAT_RELOAD = LAT_WD'(LATENCY - 1);

    logic                     req;
    logic                     addrOk;
    logic                     accept;
    logic                     dataOk;
    logic                     headValid;
    logic                     newHead;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic [CNT_WD-1:0]        fifoCount;
    logic [ENTRY_WD-1:0]      pushEntry;
    logic [ENTRY_WD-1:0]      headEntry;
    logic [SRAM_ADDR_WD-1:0]  headAddr;
    logic [SRAM_ADDR_WD-1:0]  headOffset;
    logic                     headIsWr;
    logic [SRAM_WMASK_WD-1:0] headMask;
    logic [SRAM_DATA_WD-1:0]  headWdata;
    logic [IDX_WD-1:0]        headIdx;
    logic [LAT_WD-1:0]        latCnt_q, latCnt_d;
    logic                     unusedOffset;
    logic [SRAM_DATA_WD-1:0]  mem_q [MEM_WORDS];

    assign req       = i_sram_ren | i_sram_wen;
    assign addrOk    = ~i_rst & ~fifoFull;
    assign accept    = req & addrOk;
    // A request carrying both ren and wen is stored as a write.
    assign pushEntry = {i_sram_addr, i_sram_wen, i_sram_wmask, i_sram_wdata};

    ysyx_22050710_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WD)
    ) u_reqQueue (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .push_i     (accept),
        .pushData_i (pushEntry),
        .pop_i      (dataOk),
        .headData_o (headEntry),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    assign headWdata = headEntry[SRAM_DATA_WD-1:0];
    assign headMask  = headEntry[MASK_LSB +: SRAM_WMASK_WD];
    assign headIsWr  = headEntry[ISWR_BIT];
    assign headAddr  = headEntry[ADDR_LSB +: SRAM_ADDR_WD];

    // Word index: drop the byte offset, alias anything beyond the array.
    assign headOffset   = headAddr - BASE_ADDR;
    assign headIdx      = (MEM_WORDS > 1) ? headOffset[BYTE_OFF_WD +: IDX_WD] : '0;
    assign unusedOffset = &{1'b0, headOffset};

    assign headValid = ~fifoEmpty;
    assign dataOk    = ~i_rst & headValid & (latCnt_q == '0);

    // An entry reaches the head when pushed into an empty queue, or when the
    // current head leaves and something (already queued or arriving now) follows.
    assign newHead = (accept & fifoEmpty)
                   | (dataOk & ((fifoCount > CNT_WD'(1)) | accept));

    // Head latency countdown: restart for each new head, then count to zero.
    always_comb begin
        latCnt_d = latCnt_q;
        if (newHead) begin
            latCnt_d = LAT_RELOAD;
        end else if (headValid && (latCnt_q != '0)) begin
            latCnt_d = latCnt_q - LAT_WD'(1);
        end
    end

    // Latency counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            latCnt_q <= '0;
        end else begin
            latCnt_q <= latCnt_d;
        end
    end

    // Byte-masked memory update when a write is answered; memory survives reset.
    always_ff @(posedge i_clk) begin
        if (dataOk && headIsWr) begin
            for (int b = 0; b < SRAM_WMASK_WD; b++) begin
                if (headMask[b]) begin
                    mem_q[headIdx][b*8 +: 8] <= headWdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_sram_addr_ok = addrOk;
    assign o_sram_data_ok = dataOk;
    assign o_sram_rdata   = (dataOk && !headIsWr) ? mem_q[headIdx] : '0;

endmodule

// File: tb/tb_ysyx_22050710_sram_responder.sv
// Bench for the SRAM-like responder: a LATENCY=1 and a LATENCY=3 instance,
// checked every cycle against a request-queue model that schedules each
// response from the cycle its request reached the head of the queue.
module tb_ysyx_22050710_sram_responder;

    localparam int          DEPTH = 2;
    localparam int          WORDS = 256;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    typedef struct {
        logic [31:0] addr;
        logic        isWr;
        logic [7:0]  mask;
        logic [63:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr   [2];
    logic        ren    [2];
    logic        wen    [2];
    logic [7:0]  wmask  [2];
    logic [63:0] wdata  [2];
    logic        addrOk [2];
    logic        dataOk [2];
    logic [63:0] rdata  [2];

    req_t        pend[$];
    logic [63:0] mdlMem [2][WORDS];
    int          cycle = 0;
    int          headDue = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          dokCycles[$];
    int          dokCount = 0;
    logic [63:0] lastRead = '0;

    always #5 clk = ~clk;

    ysyx_22050710_sram_responder #(.DEPTH(DEPTH), .LATENCY(1), .MEM_WORDS(WORDS)) u1 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sram_addr    (addr[0]),
        .i_sram_ren     (ren[0]),
        .i_sram_wen     (wen[0]),
        .i_sram_wmask   (wmask[0]),
        .i_sram_wdata   (wdata[0]),
        .o_sram_addr_ok (addrOk[0]),
        .o_sram_data_ok (dataOk[0]),
        .o_sram_rdata   (rdata[0])
    );

    ysyx_22050710_sram_responder #(.DEPTH(DEPTH), .LATENCY(3), .MEM_WORDS(WORDS)) u3 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sram_addr    (addr[1]),
        .i_sram_ren     (ren[1]),
        .i_sram_wen     (wen[1]),
        .i_sram_wmask   (wmask[1]),
        .i_sram_wdata   (wdata[1]),
        .o_sram_addr_ok (addrOk[1]),
        .o_sram_data_ok (dataOk[1]),
        .o_sram_rdata   (rdata[1])
    );

    function automatic int latOf(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    function automatic int idxOf(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 3;
        return int'(off % 32'(WORDS));
    endfunction

    function automatic int cycleAt(input int i);
        return (i < dokCycles.size()) ? dokCycles[i] : -1;
    endfunction

    function automatic logic [31:0] randAddr();
        int unsigned w;
        w = $urandom_range(0, 15) + 256 * $urandom_range(0, 7);
        return BASE + 32'(w * 8) + 32'($urandom_range(0, 7));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic applyStimulus(input int inst, input logic r, input logic rn, input logic wn,
                                 input logic [31:0] a, input logic [7:0] m, input logic [63:0] d,
                                 output logic accepted);
        logic        expAok;
        logic        expDok;
        logic [63:0] expRd;
        req_t        head;
        req_t        e;
        rst = r;
        for (int k = 0; k < 2; k++) begin
            ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = '0; wmask[k] = '0; wdata[k] = '0;
        end
        ren[inst] = rn; wen[inst] = wn; addr[inst] = a; wmask[inst] = m; wdata[inst] = d;
        @(negedge clk);
        expAok = !r && (pend.size() < DEPTH);
        expDok = !r && (pend.size() > 0) && (cycle == headDue);
        expRd  = '0;
        if (expDok && !pend[0].isWr) expRd = mdlMem[inst][idxOf(pend[0].addr)];
        checkOutput($sformatf("u%0d.addr_ok@%0d", inst, cycle), {63'b0, addrOk[inst]}, {63'b0, expAok});
        checkOutput($sformatf("u%0d.data_ok@%0d", inst, cycle), {63'b0, dataOk[inst]}, {63'b0, expDok});
        checkOutput($sformatf("u%0d.rdata@%0d", inst, cycle), rdata[inst], expRd);
        if (dataOk[inst] === 1'b1) begin
            dokCycles.push_back(cycle);
            dokCount++;
            lastRead = rdata[inst];
        end
        accepted = expAok && (rn || wn);
        if (r) begin
            pend.delete();
        end else begin
            if (expDok) begin
                head = pend.pop_front();
                if (head.isWr) begin
                    for (int b = 0; b < 8; b++) begin
                        if (head.mask[b]) mdlMem[inst][idxOf(head.addr)][b*8 +: 8] = head.data[b*8 +: 8];
                    end
                end
                if (pend.size() > 0) headDue = cycle + latOf(inst);
            end
            if (accepted) begin
                e.addr = a; e.isWr = wn; e.mask = m; e.data = d;
                pend.push_back(e);
                if (pend.size() == 1) headDue = cycle + latOf(inst);
            end
        end
        cycle++;
        @(posedge clk);
        #1;
    endtask

    // Hold a request until the responder accepts it, within a bounded number of cycles.
    task automatic issue(input int inst, input logic rn, input logic wn,
                         input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            applyStimulus(inst, 1'b0, rn, wn, a, m, d, acc);
            tries++;
        end
        checkOutput($sformatf("u%0d.issue_accepted", inst), {63'b0, acc}, 64'd1);
    endtask

    task automatic idle(input int inst, input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(inst, 1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
    endtask

    task automatic drain(input int inst);
        int guard;
        guard = 0;
        while (pend.size() > 0 && guard < 50) begin
            idle(inst, 1);
            guard++;
        end
        idle(inst, 1);
        checkOutput($sformatf("u%0d.drained", inst), 64'(pend.size()), 64'd0);
    endtask

    initial begin
        int          t0;
        int          snap;
        logic        acc;
        logic [63:0] d;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = '0; wmask[k] = '0; wdata[k] = '0;
        end
        @(posedge clk);
        #1;
        $display("[TB] reset");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, '0, '0, '0, acc);

        $display("[TB] preload words 0..15 on both instances");
        for (int inst = 0; inst < 2; inst++) begin
            for (int i = 0; i < 16; i++) begin
                issue(inst, 1'b0, 1'b1, BASE + 32'(i * 8), 8'hFF, {$urandom, $urandom});
            end
            drain(inst);
        end

        $display("[TB] write then read, LATENCY=1");
        dokCycles.delete();
        t0 = cycle;
        issue(0, 1'b0, 1'b1, 32'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788);
        issue(0, 1'b1, 1'b0, 32'h8000_0008, 8'h00, 64'h0);
        drain(0);
        checkOutput("t1.rdata", lastRead, 64'h1122_3344_5566_7788);
        checkOutput("t1.wr_dok_cycle", 64'(cycleAt(0)), 64'(t0 + 1));
        checkOutput("t1.rd_dok_cycle", 64'(cycleAt(1)), 64'(t0 + 2));

        $display("[TB] byte mask");
        issue(0, 1'b0, 1'b1, BASE, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(0, 1'b0, 1'b1, BASE, 8'h0F, 64'h0);
        issue(0, 1'b1, 1'b0, BASE, 8'h00, 64'h0);
        drain(0);
        checkOutput("t2.rdata", lastRead, 64'hFFFF_FFFF_0000_0000);

        $display("[TB] three back-to-back reads, LATENCY=3");
        dokCycles.delete();
        t0 = cycle;
        issue(1, 1'b1, 1'b0, BASE + 32'h10, 8'h00, 64'h0);
        issue(1, 1'b1, 1'b0, BASE + 32'h18, 8'h00, 64'h0);
        issue(1, 1'b1, 1'b0, BASE + 32'h20, 8'h00, 64'h0);
        drain(1);
        checkOutput("t3.dok_count", 64'(dokCycles.size()), 64'd3);
        checkOutput("t3.dok0_cycle", 64'(cycleAt(0)), 64'(t0 + 3));
        checkOutput("t3.dok1_cycle", 64'(cycleAt(1)), 64'(t0 + 6));
        checkOutput("t3.dok2_cycle", 64'(cycleAt(2)), 64'(t0 + 9));

        $display("[TB] continuous reads, LATENCY=1");
        snap = dokCount;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 1'b0, randAddr(), 8'h00, 64'h0, acc);
        end
        checkOutput("t4.responses_in_12", 64'(dokCount - snap), 64'd11);
        drain(0);

        $display("[TB] reset with two reads queued");
        issue(1, 1'b1, 1'b0, BASE + 32'h28, 8'h00, 64'h0);
        issue(1, 1'b1, 1'b0, BASE + 32'h30, 8'h00, 64'h0);
        snap = dokCount;
        applyStimulus(1, 1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
        idle(1, 6);
        checkOutput("t5.no_dok_after_reset", 64'(dokCount - snap), 64'd0);
        issue(1, 1'b1, 1'b0, BASE + 32'h28, 8'h00, 64'h0);
        drain(1);
        checkOutput("t5.data_kept", lastRead, mdlMem[1][5]);

        $display("[TB] alias and ren+wen as write");
        d = {$urandom, $urandom};
        issue(0, 1'b1, 1'b1, BASE + 32'(WORDS * 8), 8'hFF, d);
        issue(0, 1'b1, 1'b0, BASE, 8'h00, 64'h0);
        drain(0);
        checkOutput("t6.alias_rdata", lastRead, d);

        $display("[TB] random traffic");
        for (int inst = 0; inst < 2; inst++) begin
            for (int i = 0; i < 200; i++) begin
                applyStimulus(inst, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                              randAddr(), 8'($urandom), {$urandom, $urandom}, acc);
            end
            drain(inst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
